ex_trap_ctrl: RTL and testbench
===============================

# ex_trap_ctrl

External interrupt request controller that feeds the core's external-trap handshake (`core_ex_trap_valid` / `core_ex_trap_ready`) in `sparrow_soc`. It collects up to NUM_SRC asynchronous board-level interrupt lines and synchronises them. It latches the lines as pending events, with edge or level sensitivity per source. It then presents one request at a time, lowest index first, with a stable source ID until the core accepts it.

## Interface
- NUM_SRC, 8: number of interrupt sources, 1..32.
- SYNC_STAGES, 2: synchroniser depth, ≥2.
- IDW, $clog2(NUM_SRC) (min 1): ID width.

- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- irq_src  in  NUM_SRC  asynchronous interrupt lines.
- irq_en  in  NUM_SRC  per-source enable. Synchronous to clk.
- irq_edge  in  NUM_SRC  per-source sense: 1 = rising edge, 0 = high level.
- ovf_clr  in  NUM_SRC  one-cycle pulse per bit; clears the matching irq_ovf bit.
- core_ex_trap_valid  out  1  request to the core.
- core_ex_trap_ready  in  1  core accepts the request.
- ex_trap_id  out  IDW  index of the presented source.
- irq_pending  out  NUM_SRC  pending register.
- irq_ovf  out  NUM_SRC  sticky overflow: an edge was lost because its bit was already pending.

## Operation
- Each irq_src bit passes through a SYNC_STAGES flop chain, producing s.
- A delayed copy s_d is kept for edge detection.
- Event per bit:
  - edge mode: s & ~s_d.
  - level mode: s.
- Pending update per bit, every cycle: pend <= (pend & ~clr) | event.
  - clr is the acceptance strobe for the bit equal to ex_trap_id.
  - Set wins over clear: an event in the same cycle as its acceptance leaves the bit pending.
- Overflow, edge mode only: if an event occurs while pend=1 and that bit is not being cleared in the same cycle, set irq_ovf.
  - ovf_clr clears the bit.
  - If a new overflow and ovf_clr occur together, the new overflow wins.
- Arbitration: the candidate is the lowest index with pend & irq_en.
- A disabled source keeps its pending bit but is never presented.
- FSM:
  - IDLE: if a candidate exists, register ex_trap_id = candidate, set valid=1, go to REQ.
  - REQ: valid and ex_trap_id are held constant until core_ex_trap_ready=1 is sampled at a rising edge. That edge is the acceptance: pend[id] is cleared, valid<=0, go to GAP.
  - REQ: valid is never retracted, even if irq_en[id] drops or a higher-priority source becomes pending.
  - GAP: one cycle with valid=0, then return to IDLE. This lets a level source deassert before it can be re-requested.
- ready while valid=0 is ignored.

## Timing
- Reset values:
  - sync chains, s_d, irq_pending and irq_ovf = 0.
  - core_ex_trap_valid = 0, ex_trap_id = 0, FSM = IDLE.
- Reset mid-handshake: valid drops asynchronously and all pending state is lost.
- Latency: an irq_src rise that is captured at clock edge 1 sets pend at edge SYNC_STAGES+1. valid is registered high at edge SYNC_STAGES+2 (edge 4 for the default depth).
- Acceptance to next request: valid low for exactly 2 cycles (acceptance cycle plus GAP) when another candidate is already pending.
- Minimum spacing between accepted requests is 3 cycles.
- A pulse on irq_src shorter than one clk period may be missed. Sources must hold for at least 2 clk periods.
- ex_trap_id changes only on the IDLE→REQ transition.

## Test plan
- Edge source, single: irq_edge=8'hFF, irq_en=8'hFF. Raise irq_src[3] and hold it.
  - valid=1 with id=3 at edge 4.
  - ready is held high until acceptance; valid=0 the cycle after acceptance; irq_pending=0.
  - No second request while irq_src[3] stays high.
- Priority: raise src[5] and src[2] in the same cycle.
  - id=2 first; after acceptance plus GAP, id=5.
  - valid low for exactly 2 cycles between the two requests.
- No retraction: present id=4, then pulse src[1] and deassert irq_en[4] while ready=0.
  - valid and id=4 stay stable until ready; id=1 is presented next.
- Level source: irq_edge[0]=0, src[0] held high across 3 acceptances.
  - 3 separate requests with id=0, each separated by a 2-cycle gap.
  - After src[0] falls and the in-flight request is accepted, no further request.
- Overflow and set-wins: with en[6]=0, give src[6] two rising edges.
  - irq_ovf[6]=1; ovf_clr[6] pulse clears it.
  - An edge landing exactly on the acceptance cycle of id=6 leaves pend[6]=1 with no overflow.
- Async reset asserted in REQ:
  - valid=0 and pending=0 immediately, without waiting for a clock edge.
  - After release, no request until a new source event occurs.

Source files
------------

// File: rtl/ex_trap_ctrl.sv
// ex_trap_ctrl: external interrupt collector for the core's ex-trap handshake.
// Each source is synchronised, turned into edge/level events and latched as
// pending. One request at a time is presented, lowest index first, and its ID
// is held until the core accepts it.

// Per-source slice: synchroniser, event detect, pending and overflow flags.
module ex_trap_src #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic src_i,      // raw asynchronous line
  input  logic edge_i,     // 1 = rising edge, 0 = high level
  input  logic clr_i,      // acceptance strobe for this source
  input  logic ovf_clr_i,  // clears the sticky overflow flag
  output logic pend_o,
  output logic ovf_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;
  logic                   pend_q, pend_d;
  logic                   ovf_q, ovf_d;
  logic                   s, evt, ovf_set;

  assign s   = sync_q[SYNC_STAGES-1];
  assign evt = edge_i ? (s & ~s_d_q) : s;

  // An edge is lost only if the bit is already pending and not leaving now.
  assign ovf_set = edge_i & evt & pend_q & ~clr_i;

  // Set wins over clear so an event on the acceptance cycle is not dropped.
  assign pend_d = (pend_q & ~clr_i) | evt;
  assign ovf_d  = (ovf_q & ~ovf_clr_i) | ovf_set;

  // Synchroniser chain, edge-detect delay and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
      pend_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], src_i};
      s_d_q  <= s;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  assign pend_o = pend_q;
  assign ovf_o  = ovf_q;
endmodule

module ex_trap_ctrl #(
  parameter int NUM_SRC     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int IDW         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [NUM_SRC-1:0] irq_en,
  input  logic [NUM_SRC-1:0] irq_edge,
  input  logic [NUM_SRC-1:0] ovf_clr,
  output logic               core_ex_trap_valid,
  input  logic               core_ex_trap_ready,
  output logic [IDW-1:0]     ex_trap_id,
  output logic [NUM_SRC-1:0] irq_pending,
  output logic [NUM_SRC-1:0] irq_ovf
);
  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [NUM_SRC-1:0] pend, ovf, clr;
  logic               accept;
  logic               cand_vld;
  logic [IDW-1:0]     cand_id;

  assign accept = (state_q == REQ) & core_ex_trap_ready;

  // One slice per source; only the presented source sees the clear strobe.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign clr[g] = accept & (id_q == IDW'(g));
    ex_trap_src #(.SYNC_STAGES(SYNC_STAGES)) u_src (
      .clk       (clk),
      .rst       (rst),
      .src_i     (irq_src[g]),
      .edge_i    (irq_edge[g]),
      .clr_i     (clr[g]),
      .ovf_clr_i (ovf_clr[g]),
      .pend_o    (pend[g]),
      .ovf_o     (ovf[g])
    );
  end

  // Fixed priority: scan downward so the lowest enabled pending index wins.
  always_comb begin
    cand_vld = 1'b0;
    cand_id  = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pend[i] && irq_en[i]) begin
        cand_vld = 1'b1;
        cand_id  = IDW'(i);
      end
    end
  end

  // Handshake next state: ID is captured only when a request is launched.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      IDLE: if (cand_vld) begin
        state_d = REQ;
        id_d    = cand_id;
      end
      REQ:  if (core_ex_trap_ready) state_d = GAP;
      GAP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake state and presented ID.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
    end
  end

  // Valid is a state decode, so it drops at once on an asynchronous reset.
  assign core_ex_trap_valid = (state_q == REQ);
  assign ex_trap_id         = id_q;
  assign irq_pending        = pend;
  assign irq_ovf            = ovf;
endmodule

// File: tb/tb_ex_trap_ctrl.sv
// Directed bench for ex_trap_ctrl with a cycle-level reference model.
module tb_ex_trap_ctrl;
  localparam int NSRC = 8;
  localparam int S    = 2;
  localparam int IDW  = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [NSRC-1:0] irq_src, irq_en, irq_edge, ovf_clr;
  logic            core_ex_trap_valid, core_ex_trap_ready;
  logic [IDW-1:0]  ex_trap_id;
  logic [NSRC-1:0] irq_pending, irq_ovf;

  int checks = 0;
  int errors = 0;

  ex_trap_ctrl #(.NUM_SRC(NSRC), .SYNC_STAGES(S), .IDW(IDW)) dut (
    .clk                (clk),
    .rst                (rst),
    .irq_src            (irq_src),
    .irq_en             (irq_en),
    .irq_edge           (irq_edge),
    .ovf_clr            (ovf_clr),
    .core_ex_trap_valid (core_ex_trap_valid),
    .core_ex_trap_ready (core_ex_trap_ready),
    .ex_trap_id         (ex_trap_id),
    .irq_pending        (irq_pending),
    .irq_ovf            (irq_ovf)
  );

  always #5 clk = ~clk;

  // Reference model: history of sampled lines plus pending/overflow bits and
  // a "request outstanding / cooling down" pair.
  logic [NSRC-1:0] smp [0:S];
  logic [NSRC-1:0] m_pend, m_ovf;
  bit              m_busy, m_gap;
  int              m_id;

  task automatic model_reset();
    for (int j = 0; j <= S; j++) smp[j] = '0;
    m_pend = '0;
    m_ovf  = '0;
    m_busy = 0;
    m_gap  = 0;
    m_id   = 0;
  endtask

  task automatic model_step();
    logic [NSRC-1:0] s, sd;
    bit ev, clr, acc;
    int c;
    if (rst) begin
      model_reset();
      return;
    end
    s   = smp[S-1];  // synchronised line as seen this cycle
    sd  = smp[S];    // one cycle older
    acc = m_busy && core_ex_trap_ready;
    c   = -1;
    if (!m_busy && !m_gap)
      for (int i = 0; i < NSRC; i++)
        if (c < 0 && m_pend[i] && irq_en[i]) c = i;
    for (int i = 0; i < NSRC; i++) begin
      ev  = irq_edge[i] ? (s[i] && !sd[i]) : s[i];
      clr = acc && (m_id == i);
      if (irq_edge[i] && ev && m_pend[i] && !clr) m_ovf[i] = 1'b1;
      else if (ovf_clr[i])                         m_ovf[i] = 1'b0;
      m_pend[i] = ev || (m_pend[i] && !clr);
    end
    if (m_busy) begin
      if (acc) begin m_busy = 0; m_gap = 1; end
    end else if (m_gap) begin
      m_gap = 0;
    end else if (c >= 0) begin
      m_busy = 1;
      m_id   = c;
    end
    for (int j = S; j > 0; j--) smp[j] = smp[j-1];
    smp[0] = irq_src;
  endtask

  task automatic chk(string name, int unsigned got, int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic compare();
    chk("valid",   core_ex_trap_valid, m_busy);
    chk("id",      ex_trap_id, m_id);
    chk("pending", irq_pending, m_pend);
    chk("ovf",     irq_ovf, m_ovf);
  endtask

  // One clock: model advances on the edge, DUT is checked on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic ticks(int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wait_valid(string name, int max);
    int n = 0;
    while (!core_ex_trap_valid && n < max) begin tick(); n++; end
    chk(name, core_ex_trap_valid, 1);
  endtask

  // Called right after an acceptance edge; counts low cycles before the next valid.
  task automatic gap_check(string name);
    int n = 0;
    while (!core_ex_trap_valid && n < 10) begin n++; tick(); end
    chk(name, n, 2);
  endtask

  task automatic accept();
    core_ex_trap_ready = 1'b1;
    tick();
    core_ex_trap_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    irq_src = '0; irq_en = 8'hFF; irq_edge = 8'hFF; ovf_clr = '0;
    core_ex_trap_ready = 1'b0;
    model_reset();
    ticks(2);
    chk("rst_valid", core_ex_trap_valid, 0);
    chk("rst_id", ex_trap_id, 0);
    chk("rst_pending", irq_pending, 0);
    chk("rst_ovf", irq_ovf, 0);
    rst = 1'b0;
    ticks(2);

    // Single edge source: valid at the 4th edge after the rise.
    irq_src[3] = 1'b1;
    ticks(3);
    chk("e3_valid", core_ex_trap_valid, 0);
    chk("e3_pending", irq_pending, 8'h08);
    tick();
    chk("e4_valid", core_ex_trap_valid, 1);
    chk("e4_id", ex_trap_id, 3);
    accept();
    chk("acc_valid", core_ex_trap_valid, 0);
    chk("acc_pending", irq_pending, 8'h00);
    ticks(10);
    chk("no_rereq", core_ex_trap_valid, 0);
    irq_src[3] = 1'b0;
    ticks(3);

    // Priority between two simultaneous rises, ready held high throughout.
    irq_src[5] = 1'b1; irq_src[2] = 1'b1;
    wait_valid("prio_first", 10);
    chk("prio_id2", ex_trap_id, 2);
    core_ex_trap_ready = 1'b1;
    tick();
    gap_check("prio_gap");
    chk("prio_id5", ex_trap_id, 5);
    tick();
    core_ex_trap_ready = 1'b0;
    irq_src = '0;
    ticks(4);

    // No retraction while a higher-priority source arrives and enable drops.
    irq_src[4] = 1'b1;
    wait_valid("nr_first", 10);
    chk("nr_id4", ex_trap_id, 4);
    irq_src[1] = 1'b1; irq_en[4] = 1'b0;
    ticks(2);
    irq_src[1] = 1'b0;
    ticks(4);
    chk("nr_hold_valid", core_ex_trap_valid, 1);
    chk("nr_hold_id", ex_trap_id, 4);
    accept();
    wait_valid("nr_second", 10);
    chk("nr_id1", ex_trap_id, 1);
    accept();
    irq_en[4] = 1'b1; irq_src[4] = 1'b0;
    ticks(4);

    // Level source held high across three acceptances.
    irq_edge[0] = 1'b0; irq_src[0] = 1'b1;
    wait_valid("lvl_req1", 10);
    chk("lvl_id_a", ex_trap_id, 0);
    accept();
    gap_check("lvl_gap1");
    chk("lvl_id_b", ex_trap_id, 0);
    accept();
    gap_check("lvl_gap2");
    chk("lvl_id_c", ex_trap_id, 0);
    irq_src[0] = 1'b0;
    ticks(4);
    accept();
    ticks(8);
    chk("lvl_done_valid", core_ex_trap_valid, 0);
    chk("lvl_done_pending", irq_pending, 8'h00);
    irq_edge[0] = 1'b1;

    // Overflow on a disabled edge source, then clear.
    irq_en[6] = 1'b0;
    irq_src[6] = 1'b1; ticks(2); irq_src[6] = 1'b0; ticks(2);
    irq_src[6] = 1'b1; ticks(2); irq_src[6] = 1'b0; ticks(4);
    chk("ovf_set", irq_ovf, 8'h40);
    chk("ovf_pend", irq_pending, 8'h40);
    chk("ovf_masked", core_ex_trap_valid, 0);
    ovf_clr[6] = 1'b1; tick(); ovf_clr[6] = 1'b0;
    chk("ovf_clr", irq_ovf, 8'h00);

    // Set wins: an edge lands on the acceptance cycle of id 6.
    irq_en[6] = 1'b1;
    wait_valid("sw_req", 10);
    chk("sw_id", ex_trap_id, 6);
    irq_src[6] = 1'b1;
    ticks(2);
    accept();
    chk("sw_pend", irq_pending, 8'h40);
    chk("sw_noovf", irq_ovf, 8'h00);
    wait_valid("sw_rereq", 10);
    chk("sw_id2", ex_trap_id, 6);
    accept();
    irq_src[6] = 1'b0;
    ticks(4);

    // Asynchronous reset while a request is outstanding.
    irq_src[2] = 1'b1;
    wait_valid("ar_req", 10);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid_now", core_ex_trap_valid, 0);
    chk("ar_pend_now", irq_pending, 8'h00);
    model_reset();
    irq_src[2] = 1'b0;
    tick();
    rst = 1'b0;
    ticks(10);
    chk("ar_quiet", core_ex_trap_valid, 0);
    irq_src[2] = 1'b1;
    wait_valid("ar_new", 10);
    chk("ar_id", ex_trap_id, 2);
    accept();
    irq_src[2] = 1'b0;
    ticks(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
